// File: rtl/apb_intc_regs.sv
// apb_intc_regs: APB4 interrupt controller register file with edge capture, enable mask,
// odd-parity checking on every transfer and a registered irq output.
module apb_intc_regs #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_SRC     = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [ADDR_WIDTH-1:0]     PADDR,
   input  logic [DATA_WIDTH-1:0]     PWDATA,
   input  logic [DATA_WIDTH/8-1:0]   PSTRB,
   input  logic [ADDR_WIDTH/8-1:0]   PADDRCHK,
   input  logic [DATA_WIDTH/8-1:0]   PWDATACHK,
   input  logic                      PSTRBCHK,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [DATA_WIDTH-1:0]     PRDATA,
   output logic [DATA_WIDTH/8-1:0]   PRDATACHK,
   input  logic [NUM_SRC-1:0]        irq_src,
   output logic                      irq
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AB = ADDR_WIDTH / 8;
   typedef enum logic {S_IDLE, S_ACCESS} state_t;
   state_t               r_state, w_state_nxt;
   logic [2:0]           r_cnt, w_cnt_nxt;
   logic [NUM_SRC-1:0]   r_raw, r_en, r_src_q;
   logic [NUM_SRC-1:0]   w_raw_nxt, w_en_nxt, w_rise, w_clr, w_wsrc, w_bmask, w_sel;
   logic [DATA_WIDTH-1:0] w_rd_nxt;
   logic [NB-1:0]        w_wdata_par;
   logic [AB-1:0]        w_paddr_par;
   logic [11:0]          w_off;
   logic                 w_setup, w_last, w_rdy_nxt, w_err_nxt, w_bad_par, w_bad_dec, w_commit;
   for (genvar i = 0; i < NB; i++) begin : g_dbyte
      assign w_wdata_par[i] = ~^PWDATA[8*i +: 8];
      assign PRDATACHK[i]   = ~^PRDATA[8*i +: 8];
   end
   for (genvar i = 0; i < AB; i++) begin : g_abyte
      assign w_paddr_par[i] = ~^PADDR[8*i +: 8];
   end
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_mask
      assign w_bmask[i] = PSTRB[i/8];
   end
   assign w_off   = PADDR[11:0];
   assign w_setup = PSEL & ~PENABLE;
   assign w_last  = (r_state == S_ACCESS) && (r_cnt == 3'(WAIT_STATES));
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (r_state == S_IDLE) begin
         w_state_nxt = w_setup ? S_ACCESS : S_IDLE;
         w_cnt_nxt   = '0;
      end else if (!PSEL) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else if (w_last) begin
         w_state_nxt = w_setup ? S_ACCESS : S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         w_cnt_nxt   = r_cnt + 3'd1;
      end
   end
   // RO registers (RAW at 0x0, PENDING at 0x8) have PADDR[2]=0, so a write there is a decode error
   always_comb begin
      w_bad_par = (|(PADDRCHK ^ w_paddr_par)) |
                  (PWRITE & ((|(PWDATACHK ^ w_wdata_par)) | (PSTRBCHK ^ ~^PSTRB)));
      w_bad_dec = (|w_off[11:4]) | (|w_off[1:0]) | (PWRITE & ~w_off[2]);
      w_rdy_nxt = (w_state_nxt == S_ACCESS) && (w_cnt_nxt == 3'(WAIT_STATES));
      w_err_nxt = w_rdy_nxt & (w_bad_par | w_bad_dec);
      w_sel     = (w_off[3:2] == 2'd0) ? w_raw_nxt :
                  (w_off[3:2] == 2'd1) ? w_en_nxt :
                  (w_off[3:2] == 2'd2) ? (w_raw_nxt & w_en_nxt) : '0;
      w_rd_nxt  = (w_rdy_nxt & ~PWRITE & ~w_bad_par & ~w_bad_dec) ? DATA_WIDTH'(w_sel) : '0;
   end
   // Commit at the edge closing the PREADY cycle; the error flag was registered with PREADY
   assign w_commit  = PREADY & ~PSLVERR & PSEL & PENABLE & PWRITE;
   assign w_wsrc    = PWDATA[NUM_SRC-1:0] & w_bmask;
   assign w_clr     = (w_commit & w_off[3]) ? w_wsrc : '0;
   assign w_en_nxt  = (w_commit & ~w_off[3]) ? ((r_en & ~w_bmask) | w_wsrc) : r_en;
   assign w_rise    = irq_src & ~r_src_q;
   assign w_raw_nxt = (r_raw & ~w_clr) | w_rise;
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         irq     <= 1'b0;
         r_raw   <= '0;
         r_en    <= '0;
         r_src_q <= '0;
      end else begin
         PREADY  <= w_rdy_nxt;
         PSLVERR <= w_err_nxt;
         PRDATA  <= w_rd_nxt;
         irq     <= |(w_raw_nxt & w_en_nxt);
         r_raw   <= w_raw_nxt;
         r_en    <= w_en_nxt;
         r_src_q <= irq_src;
      end
   end
endmodule

// File: tb/tb_apb_intc_regs.sv
// tb_apb_intc_regs: directed checks of the APB interrupt register file, with a second
// instance built for zero wait states to confirm single-cycle access timing.
module tb_apb_intc_regs;
   logic        PCLK = 1'b0;
   logic        PRESET, PSEL, PENABLE, PWRITE, PSTRBCHK;
   logic [31:0] PADDR, PWDATA;
   logic [3:0]  PSTRB, PADDRCHK, PWDATACHK;
   logic [7:0]  irq_src;
   logic        PREADY, PSLVERR, irq, PREADY0, PSLVERR0, irq0;
   logic [31:0] PRDATA, PRDATA0;
   logic [3:0]  PRDATACHK, PRDATACHK0;
   int          n_chk = 0, n_bad = 0;
   logic [31:0] rd;
   logic        err, rdy0;
   logic [3:0]  rchk;
   int          lat;
   always #5 PCLK = ~PCLK;
   apb_intc_regs #(.WAIT_STATES(1)) u_dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK),
      .PWDATACHK(PWDATACHK), .PSTRBCHK(PSTRBCHK), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .PRDATA(PRDATA), .PRDATACHK(PRDATACHK), .irq_src(irq_src), .irq(irq)
   );
   apb_intc_regs #(.WAIT_STATES(0)) u_dut0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK),
      .PWDATACHK(PWDATACHK), .PSTRBCHK(PSTRBCHK), .PREADY(PREADY0), .PSLVERR(PSLVERR0),
      .PRDATA(PRDATA0), .PRDATACHK(PRDATACHK0), .irq_src(irq_src), .irq(irq0)
   );
   function automatic logic [3:0] par(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ~^d[8*i +: 8];
      return p;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Starts a transfer at the current falling edge; returns at the falling edge after PREADY.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [3:0] aflip, input logic [3:0] wflip,
                       input logic sflip, input logic [7:0] rise);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
      PADDRCHK = par(addr) ^ aflip; PWDATACHK = par(data) ^ wflip; PSTRBCHK = (~^strb) ^ sflip;
      @(negedge PCLK);
      PENABLE = 1'b1;
      lat = 1;
      rdy0 = PREADY0;
      while (!PREADY && lat < 16) begin
         @(negedge PCLK);
         lat++;
      end
      if (!PREADY) check("timeout", 32'(PREADY), 32'd1);
      rd = PRDATA; err = PSLVERR; rchk = PRDATACHK;
      irq_src = irq_src | rise;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
      PADDRCHK = 4'hF; PWDATACHK = 4'hF; PSTRBCHK = 1'b1; irq_src = '0;
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;
      check("rst_ready", 32'(PREADY), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_rdata", PRDATA, 0);
      check("rst_rchk", 32'(PRDATACHK), 32'hF);
      check("rst0_outs", {PRDATA0[27:0], PRDATACHK0}, 32'h0000000F);
      check("rst0_flags", {PREADY0, PSLVERR0, irq0}, 0);
      xfer(1, 32'h4, 32'h05, 4'b0001, 0, 0, 0, 0);
      check("en_wr_lat", lat, 2);
      check("en_wr_err", 32'(err), 0);
      xfer(0, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      check("en_rd", rd, 32'h05);
      check("ws0_rdy", 32'(rdy0), 1);
      irq_src = 8'h01;
      @(negedge PCLK);
      check("irq_rise", 32'(irq), 1);
      irq_src = 8'h00;
      xfer(0, 32'h8, 0, 4'b0000, 0, 0, 0, 0);
      check("pend_rd", rd, 32'h01);
      check("pend_chk", 32'(rchk), 32'hE);
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("raw_rd", rd, 32'h01);
      xfer(1, 32'hC, 32'h01, 4'b0001, 0, 0, 0, 8'h01);
      check("race_irq", 32'(irq), 1);
      irq_src = 8'h00;
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("race_raw", rd, 32'h01);
      xfer(1, 32'hC, 32'h01, 4'b0001, 0, 0, 0, 0);
      check("clr_irq", 32'(irq), 0);
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("clr_raw", rd, 0);
      irq_src = 8'h02;
      @(negedge PCLK);
      check("mask_irq", 32'(irq), 0);
      irq_src = 8'h00;
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("mask_raw", rd, 32'h02);
      xfer(0, 32'h8, 0, 4'b0000, 0, 0, 0, 0);
      check("mask_pend", rd, 0);
      xfer(1, 32'hC, 32'h02, 4'b0001, 0, 0, 0, 0);
      xfer(1, 32'h4, 32'hFF, 4'b0001, 0, 4'b0001, 0, 0);
      check("wpar_err", 32'(err), 1);
      check("wpar_lat", lat, 2);
      xfer(1, 32'h4, 32'hFF, 4'b0001, 0, 0, 1, 0);
      check("spar_err", 32'(err), 1);
      xfer(0, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      check("par_en_kept", rd, 32'h05);
      xfer(0, 32'h4, 0, 4'b0000, 4'b0010, 0, 0, 0);
      check("apar_err", 32'(err), 1);
      check("apar_rd", rd, 0);
      check("apar_chk", 32'(rchk), 32'hF);
      xfer(0, 32'h10, 0, 4'b0000, 0, 0, 0, 0);
      check("unmap_err", 32'(err), 1);
      xfer(1, 32'h0, 32'h01, 4'b0001, 0, 0, 0, 0);
      check("wr_raw_err", 32'(err), 1);
      xfer(1, 32'h8, 32'h01, 4'b0001, 0, 0, 0, 0);
      check("wr_pend_err", 32'(err), 1);
      xfer(0, 32'h6, 0, 4'b0000, 0, 0, 0, 0);
      check("misal_err", 32'(err), 1);
      xfer(0, 32'hC, 0, 4'b0000, 0, 0, 0, 0);
      check("clr_rd", {rd[30:0], err}, 0);
      xfer(0, 32'h1000_0004, 0, 4'b0000, 0, 0, 0, 0);
      check("hi_addr_rd", rd, 32'h05);
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("b2b_lat0", lat, 2);
      check("b2b_rd0", rd, 0);
      xfer(0, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      check("b2b_lat1", lat, 2);
      check("b2b_rd1", rd, 32'h05);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h4; PWDATA = 32'hFF; PSTRB = 4'b0001;
      PADDRCHK = par(32'h4); PWDATACHK = par(32'hFF); PSTRBCHK = ~^4'b0001;
      @(negedge PCLK);
      check("abort_wait", 32'(PREADY), 0);
      PSEL = 0; PENABLE = 1;
      @(negedge PCLK);
      check("abort_rdy0", 32'(PREADY), 0);
      PENABLE = 0;
      @(negedge PCLK);
      check("abort_rdy1", 32'(PREADY), 0);
      xfer(0, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      check("abort_en", rd, 32'h05);
      irq_src = 8'h04;
      @(negedge PCLK);
      check("pre_rst_irq", 32'(irq), 1);
      irq_src = 8'h00;
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h4; PWDATA = 32'hFF; PSTRB = 4'b0001;
      PADDRCHK = par(32'h4); PWDATACHK = par(32'hFF); PSTRBCHK = ~^4'b0001;
      @(negedge PCLK);
      PENABLE = 1;
      @(negedge PCLK);
      check("pre_rst_rdy", 32'(PREADY), 1);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("mid_rst_rdy", 32'(PREADY), 0);
      check("mid_rst_irq", 32'(irq), 0);
      check("mid_rst_chk", 32'(PRDATACHK), 32'hF);
      PRESET = 1'b0; PSEL = 0; PENABLE = 0;
      @(negedge PCLK);
      xfer(0, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      check("post_rst_en", rd, 0);
      xfer(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0);
      check("post_rst_raw", rd, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
